// File: rtl/ssp_test_pkg.sv
// Shared mode encodings and default constants for the SSP test/loopback engine.
package ssp_test_pkg;

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'b00,
        MODE_RX         = 2'b01,
        MODE_TX         = 2'b10,
        MODE_BYPASS_ALT = 2'b11
    } ssp_mode_e;

    localparam logic [31:0] DEF_PATTERN   = 32'hDEADBEEF;
    localparam logic [7:0]  DEF_MATCH_VAL = 8'hAD;

endpackage

// File: rtl/ssp_tick_gen.sv
// Divide-by-DIV counter producing a one-cycle tick; clr restarts the count and suppresses that cycle's tick.
module ssp_tick_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_MAX) && !clr;

endmodule

// File: rtl/ssp_test_engine.sv
// SSP test/loopback engine: bypass forwarding, self-clocked pattern transmit, receive with command match.
// Optional SSP_TEST_ERRCNT_EN adds a saturating receive bit-error counter (err_cnt).
module ssp_test_engine #(
    parameter int WORD_W  = 32,
    parameter int FRAME_W = 8,
    parameter int DIV     = 8,
    parameter int MATCH_W = 8,
    parameter logic [MATCH_W-1:0] MATCH_VAL = MATCH_W'(ssp_test_pkg::DEF_MATCH_VAL),
    parameter logic [WORD_W-1:0]  PATTERN   = WORD_W'(ssp_test_pkg::DEF_PATTERN)
) (
    input  logic              ck_1356meg,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              hi_ssp_clk,
    input  logic              hi_ssp_frame,
    input  logic              hi_ssp_din,
    input  logic              ssp_dout,
    output logic              ssp_clk,
    output logic              ssp_frame,
    output logic              ssp_din,
    output logic              matched,
    output logic [WORD_W-1:0] rx_word
`ifdef SSP_TEST_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt
`endif
);
    import ssp_test_pkg::*;

    localparam int PH_W = $clog2(2 * FRAME_W);
    localparam logic [PH_W-1:0] PH_MAX = PH_W'(2 * FRAME_W - 1);

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] w);
        return {w[WORD_W-2:0], w[WORD_W-1]};
    endfunction

    logic [1:0]        mode_p1;
    logic              hi_clk_p1;
    logic              rx_vld_p1;
    logic [PH_W-1:0]   ph;
    logic [WORD_W-1:0] tx_word;
    logic              tick;
    logic              mode_chg;
    logic              is_tx;
    logic              is_rx;
    logic              rx_rise;

    assign mode_chg = (mode != mode_p1);
    assign is_tx    = (mode == MODE_TX);
    assign is_rx    = (mode == MODE_RX);
    assign rx_rise  = is_rx && hi_ssp_clk && !hi_clk_p1;

    ssp_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (ck_1356meg),
        .rst  (rst),
        .clr  (mode_chg),
        .tick (tick)
    );

    // Stage p1: mode/edge history, SSP outputs, shift registers
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            mode_p1   <= MODE_BYPASS;
            hi_clk_p1 <= 1'b0;
            rx_vld_p1 <= 1'b0;
            ph        <= '0;
            tx_word   <= '0;
            ssp_clk   <= 1'b0;
            ssp_frame <= 1'b0;
            ssp_din   <= 1'b0;
            matched   <= 1'b0;
            rx_word   <= '0;
        end else begin
            mode_p1   <= mode;
            hi_clk_p1 <= hi_ssp_clk;
            rx_vld_p1 <= rx_rise;

            if (rx_rise) begin
                rx_word <= {rx_word[WORD_W-2:0], ssp_dout};
            end

            if (is_tx) begin
                // Entering transmit parks the SSP lines low so the first tick is a clean rise
                if (mode_chg) begin
                    ph        <= '0;
                    tx_word   <= matched ? '1 : PATTERN;
                    ssp_clk   <= 1'b0;
                    ssp_frame <= 1'b0;
                    ssp_din   <= 1'b0;
                end else if (tick) begin
                    if (!ph[0]) begin
                        ssp_clk   <= 1'b1;
                        ssp_din   <= tx_word[WORD_W-1];
                        tx_word   <= rotl(tx_word);
                        ssp_frame <= (ph == '0);
                    end else begin
                        ssp_clk <= 1'b0;
                    end
                    ph <= (ph == PH_MAX) ? '0 : ph + 1'b1;
                end
            end else begin
                if (mode_chg) begin
                    ph <= '0;
                end
                ssp_clk   <= hi_ssp_clk;
                ssp_frame <= hi_ssp_frame;
                ssp_din   <= is_rx ? 1'b0 : hi_ssp_din;
            end

            // Match check looks at the word one cycle after it shifted, so it survives an rx->tx switch
            if (!is_tx && !is_rx) begin
                matched <= 1'b0;
            end else if (rx_vld_p1 && (rx_word[MATCH_W-1:0] == MATCH_VAL)) begin
                matched <= 1'b1;
            end
        end
    end

`ifdef SSP_TEST_ERRCNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [WORD_W-1:0] exp_word;
    logic [WORD_W-1:0] exp_cur;

    assign exp_cur = (is_rx && mode_chg) ? PATTERN : exp_word;

    // Stage p1: reference pattern and error count
    always_ff @(posedge ck_1356meg) begin
        if (rst) begin
            exp_word <= '0;
            err_cnt  <= '0;
        end else begin
            if (!is_tx && !is_rx) begin
                err_cnt <= '0;
            end else if (rx_rise && (ssp_dout != exp_cur[WORD_W-1])) begin
                err_cnt <= sat_inc16(err_cnt);
            end
            exp_word <= rx_rise ? rotl(exp_cur) : exp_cur;
        end
    end
`endif

endmodule

// File: tb/tb_ssp_test_engine.sv
// Directed bench for ssp_test_engine (DIV=4, FRAME_W=8): reset, transmit, receive/match, bypass, mid-run reset.
module tb_ssp_test_engine;

    logic        ck_1356meg = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'b00;
    logic        hi_ssp_clk = 1'b0;
    logic        hi_ssp_frame = 1'b0;
    logic        hi_ssp_din = 1'b0;
    logic        ssp_dout = 1'b0;
    logic        ssp_clk;
    logic        ssp_frame;
    logic        ssp_din;
    logic        matched;
    logic [31:0] rx_word;
`ifdef SSP_TEST_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ssp_test_engine #(
        .WORD_W  (32),
        .FRAME_W (8),
        .DIV     (4),
        .MATCH_W (8)
    ) dut (
        .ck_1356meg   (ck_1356meg),
        .rst          (rst),
        .mode         (mode),
        .hi_ssp_clk   (hi_ssp_clk),
        .hi_ssp_frame (hi_ssp_frame),
        .hi_ssp_din   (hi_ssp_din),
        .ssp_dout     (ssp_dout),
        .ssp_clk      (ssp_clk),
        .ssp_frame    (ssp_frame),
        .ssp_din      (ssp_din),
        .matched      (matched),
        .rx_word      (rx_word)
`ifdef SSP_TEST_ERRCNT_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #5 ck_1356meg = ~ck_1356meg;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ck_1356meg);
        @(negedge ck_1356meg);
    endtask

    // Enter transmit and record nbits data bits at each ssp_clk rise, plus clk/frame waveform errors
    task automatic tx_run(input int nbits, output logic [63:0] cap,
                          output int clk_err, output int frm_err);
        logic e_clk;
        logic e_frm;
        cap = '0;
        clk_err = 0;
        frm_err = 0;
        mode = 2'b10;
        for (int c = 0; c < 4 + 8 * nbits; c++) begin
            step();
            e_clk = (c >= 4) && (((c - 4) % 8) < 4);
            e_frm = (c >= 4) && (((c - 4) % 64) < 8);
            if (ssp_clk !== e_clk) clk_err++;
            if (ssp_frame !== e_frm) frm_err++;
            if (c >= 4 && ((c - 4) % 8) == 0) cap = {cap[62:0], ssp_din};
        end
    endtask

    // One hi_ssp_clk low/high cycle carrying bit b; returns right after the sampling edge
    task automatic rx_bit(input logic b);
        hi_ssp_clk = 1'b0;
        ssp_dout   = b;
        step();
        hi_ssp_clk = 1'b1;
        step();
    endtask

    logic [63:0] cap;
    int          clk_err;
    int          frm_err;
    logic [2:0]  prev;
    logic [2:0]  pat;
    logic [7:0]  rx_bits;
    logic [2:0]  byp_pats [4];
`ifdef SSP_TEST_ERRCNT_EN
    logic [31:0] err_word;
`endif

    initial begin
        byp_pats[0] = 3'b101;
        byp_pats[1] = 3'b010;
        byp_pats[2] = 3'b111;
        byp_pats[3] = 3'b000;

        hi_ssp_clk = 1'b1;
        hi_ssp_frame = 1'b1;
        hi_ssp_din = 1'b1;
        repeat (3) step();
        check("rst_clk",     32'(ssp_clk),   32'd0);
        check("rst_frame",   32'(ssp_frame), 32'd0);
        check("rst_din",     32'(ssp_din),   32'd0);
        check("rst_matched", 32'(matched),   32'd0);
        check("rst_rx_word", rx_word,        32'd0);

        rst = 1'b0;
        hi_ssp_clk = 1'b0;
        hi_ssp_frame = 1'b0;
        hi_ssp_din = 1'b0;
        tx_run(40, cap, clk_err, frm_err);
        check("tx_clk_wave",   32'(clk_err), 32'd0);
        check("tx_frame_wave", 32'(frm_err), 32'd0);
        check("tx_word",       cap[39:8],    32'hDEADBEEF);
        check("tx_repeat_de",  32'(cap[7:0]), 32'h000000DE);

        mode = 2'b01;
        rx_bits = 8'b1010_1101;
        for (int i = 7; i >= 1; i--) rx_bit(rx_bits[i]);
        check("rx_pre_match", 32'(matched), 32'd0);
        rx_bit(rx_bits[0]);
        check("rx_word",      rx_word,        32'h000000AD);
        check("rx_clk_fwd",   32'(ssp_clk),   32'd1);
        check("rx_din_zero",  32'(ssp_din),   32'd0);
        check("rx_match_lat", 32'(matched),   32'd0);
        hi_ssp_clk = 1'b0;
        step();
        check("rx_matched",   32'(matched),   32'd1);

        tx_run(32, cap, clk_err, frm_err);
        check("tx_ones_word",    cap[31:0],      32'hFFFFFFFF);
        check("tx_ones_frame",   32'(frm_err),   32'd0);
        check("tx_keep_matched", 32'(matched),   32'd1);

        mode = 2'b00;
        step();
        check("byp_clr_matched", 32'(matched), 32'd0);

        tx_run(8, cap, clk_err, frm_err);
        check("tx_again_de", 32'(cap[7:0]), 32'h000000DE);

        mode = 2'b00;
        {hi_ssp_clk, hi_ssp_frame, hi_ssp_din} = 3'b000;
        step();
        prev = 3'b000;
        for (int i = 0; i < 4; i++) begin
            pat = byp_pats[i];
            {hi_ssp_clk, hi_ssp_frame, hi_ssp_din} = pat;
            check("byp_hold", 32'({ssp_clk, ssp_frame, ssp_din}), 32'(prev));
            step();
            check("byp_follow", 32'({ssp_clk, ssp_frame, ssp_din}), 32'(pat));
            prev = pat;
        end
        check("byp_rx_hold", rx_word, 32'h000000AD);

`ifdef SSP_TEST_ERRCNT_EN
        {hi_ssp_clk, hi_ssp_frame, hi_ssp_din} = 3'b000;
        step();
        mode = 2'b01;
        err_word = 32'hDEADBEEF ^ 32'h0010_0408;
        for (int i = 31; i >= 0; i--) rx_bit(err_word[i]);
        hi_ssp_clk = 1'b0;
        step();
        check("err_cnt3", 32'(err_cnt), 32'd3);
        mode = 2'b00;
        step();
        check("err_cnt_clr", 32'(err_cnt), 32'd0);
`endif

        {hi_ssp_clk, hi_ssp_frame, hi_ssp_din} = 3'b000;
        mode = 2'b10;
        for (int c = 0; c < 6; c++) step();
        check("pre_rst_clk", 32'({ssp_clk, ssp_frame, ssp_din}), 32'h7);
        rst = 1'b1;
        step();
        check("mid_rst_out",     32'({ssp_clk, ssp_frame, ssp_din}), 32'd0);
        check("mid_rst_matched", 32'(matched), 32'd0);
        check("mid_rst_rx_word", rx_word,      32'd0);
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
